drom_loader: RTL and testbench

Upstream load sequencer for drom_unit. It takes a little-endian byte stream (from the SPI-flash or UART boot reader) over a valid/ready handshake and packs it into 32-bit words. It drives the DROM external-access port (ext_acc, we, din) so the DROM image is written sequentially from word 0. It reports busy, done, error, word count and an additive checksum to the boot controller.

---
 rtl/drom_loader_pkg.sv | 17 +
 rtl/drom_byte_packer.sv | 45 ++++
 rtl/drom_loader.sv | 115 +++++++++++
 tb/tb_drom_loader.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drom_loader_pkg.sv
// rtl/drom_loader_pkg.sv - shared state encodings and word geometry for the DROM loader
package drom_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE    = 3'd0,
    LDR_ARM     = 3'd1,
    LDR_COLLECT = 3'd2,
    LDR_WRITE   = 3'd3,
    LDR_DONE    = 3'd4,
    LDR_ERROR   = 3'd5
  } ldr_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_WIDTH      = $clog2(BYTES_PER_WORD);
  localparam int WORD_BITS      = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/drom_byte_packer.sv
// rtl/drom_byte_packer.sv - little-endian byte-lane insert register with lane index
module drom_byte_packer
  import drom_loader_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 accept_i,
  input  logic [7:0]           byte_i,
  output logic [WORD_BITS-1:0] word_o,
  output logic                 word_full_o
);

  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [WORD_BITS-1:0] word_q, word_d;

  // Only the addressed lane is overwritten, so the previous word stays visible
  // on the DROM data bus until its lane 0 is replaced.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (accept_i) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (idx_q == IDX_WIDTH'(i)) word_d[8*i +: 8] = byte_i;
      end
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = accept_i && !clear_i && (idx_q == IDX_WIDTH'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/drom_loader.sv
// rtl/drom_loader.sv - packs a byte stream into 32-bit words and writes them into the DROM
module drom_loader
  import drom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int WORD_COUNT     = 768,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  ext_acc_o,
  output logic                  we_o,
  output logic [31:0]           din_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   word_cnt_o,
  output logic [31:0]           checksum_o
);

  localparam logic [ADDR_WIDTH:0]      WORDS_LAST = (ADDR_WIDTH + 1)'(WORD_COUNT);
  localparam logic [TIMEOUT_WIDTH:0]   TMO_LIMIT  = (TIMEOUT_WIDTH + 1)'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_MAX    = '1;

  ldr_state_e               state_q, state_d;
  logic [ADDR_WIDTH:0]      word_cnt_q, word_cnt_d;
  logic [31:0]              checksum_q, checksum_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [TIMEOUT_WIDTH:0]   tmo_inc;
  logic                     tmo_hit;
  logic                     accept;
  logic                     pack_clear;
  logic                     word_full;
  logic [WORD_BITS-1:0]     word;

  assign accept  = byte_valid_i && (state_q == LDR_COLLECT);
  assign tmo_inc = {1'b0, tmo_q} + 1'b1;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_inc >= TMO_LIMIT);

  drom_byte_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (pack_clear),
    .accept_i    (accept),
    .byte_i      (byte_i),
    .word_o      (word),
    .word_full_o (word_full)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    checksum_d = checksum_q;
    tmo_d      = tmo_q;
    pack_clear = 1'b0;
    case (state_q)
      LDR_IDLE, LDR_DONE, LDR_ERROR: begin
        if (start_i) begin
          state_d    = LDR_ARM;
          word_cnt_d = '0;
          checksum_d = '0;
          tmo_d      = '0;
          pack_clear = 1'b1;
        end
      end
      // One cycle with ext_acc high and no write lets the DROM reset its address.
      LDR_ARM: state_d = LDR_COLLECT;
      LDR_COLLECT: begin
        if (accept) begin
          tmo_d = '0;
          if (word_full) state_d = LDR_WRITE;
        end else begin
          if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
          if (tmo_hit) state_d = LDR_ERROR;
        end
      end
      LDR_WRITE: begin
        word_cnt_d = word_cnt_q + 1'b1;
        checksum_d = checksum_q + word;
        state_d    = (word_cnt_d == WORDS_LAST) ? LDR_DONE : LDR_COLLECT;
      end
      default: state_d = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= LDR_IDLE;
      word_cnt_q <= '0;
      checksum_q <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      checksum_q <= checksum_d;
      tmo_q      <= tmo_d;
    end
  end

  assign ext_acc_o    = (state_q == LDR_ARM) || (state_q == LDR_COLLECT) || (state_q == LDR_WRITE);
  assign busy_o       = ext_acc_o;
  assign byte_ready_o = (state_q == LDR_COLLECT);
  assign we_o         = (state_q == LDR_WRITE);
  assign done_o       = (state_q == LDR_DONE);
  assign err_o        = (state_q == LDR_ERROR);
  assign din_o        = word;
  assign word_cnt_o   = word_cnt_q;
  assign checksum_o   = checksum_q;

endmodule

// File: tb/tb_drom_loader.sv
// tb/tb_drom_loader.sv - randomized self-checking bench for drom_loader with a DROM address model
module tb_drom_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic rst = 1'b1;

  logic        a_start = 1'b0, a_valid = 1'b0;
  logic [7:0]  a_byte = 8'h00;
  logic        a_ready, a_ext, a_we, a_busy, a_done, a_err;
  logic [31:0] a_din, a_sum;
  logic [10:0] a_cnt;

  logic        b_start = 1'b0, b_valid = 1'b0;
  logic [7:0]  b_byte = 8'h00;
  logic        b_ready, b_ext, b_we, b_busy, b_done, b_err;
  logic [31:0] b_din, b_sum;
  logic [10:0] b_cnt;

  drom_loader #(.ADDR_WIDTH(10), .WORD_COUNT(2), .TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .byte_i(a_byte), .byte_valid_i(a_valid),
    .byte_ready_o(a_ready), .ext_acc_o(a_ext), .we_o(a_we), .din_o(a_din), .busy_o(a_busy),
    .done_o(a_done), .err_o(a_err), .word_cnt_o(a_cnt), .checksum_o(a_sum)
  );

  drom_loader #(.ADDR_WIDTH(10), .WORD_COUNT(768), .TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .byte_i(b_byte), .byte_valid_i(b_valid),
    .byte_ready_o(b_ready), .ext_acc_o(b_ext), .we_o(b_we), .din_o(b_din), .busy_o(b_busy),
    .done_o(b_done), .err_o(b_err), .word_cnt_o(b_cnt), .checksum_o(b_sum)
  );

  logic [7:0]  tx_q[$];
  logic [7:0]  tx_b[$];
  logic [31:0] a_wr_q[$];
  int          a_we_cyc[$];
  int          a_early = 0;
  logic        a_prev_ext = 1'b0;

  // DROM model: address returns to 0 on the ext_acc rising edge, advances per write.
  logic [31:0] b_mem[0:1023];
  int          b_addr = 0;
  int          b_writes = 0;
  logic        b_prev_ext = 1'b0;

  always @(negedge clk) begin
    if (a_we) begin
      if (!a_prev_ext) a_early++;
      a_wr_q.push_back(a_din);
      a_we_cyc.push_back(cyc);
    end
    a_prev_ext = a_ext;
  end

  always @(negedge clk) begin
    if (b_ext && !b_prev_ext) b_addr = 0;
    if (b_we) begin
      if (b_addr < 1024) b_mem[b_addr] = b_din;
      b_addr++;
      b_writes++;
    end
    b_prev_ext = b_ext;
  end

  function automatic logic [31:0] exp_word(int k);
    return {tx_q[4*k+3], tx_q[4*k+2], tx_q[4*k+1], tx_q[4*k]};
  endfunction

  function automatic logic [31:0] exp_sum(int nwords);
    logic [31:0] s = 32'h0;
    for (int k = 0; k < nwords; k++) s = s + exp_word(k);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_pulse_start();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  // mode 0: valid held high, 1: valid low one cycle before each byte, 2: random gaps
  task automatic a_send(input int lo, input int hi, input int mode);
    int w;
    for (int i = lo; i < hi; i++) begin
      if (mode == 1) begin
        a_valid = 1'b0;
        tick();
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          a_valid = 1'b0;
          tick();
        end
      end
      a_valid = 1'b1;
      a_byte  = tx_q[i];
      w = 0;
      while (1) begin
        @(negedge clk);
        if (a_ready) break;
        w++;
        if (w > 40) begin
          n_cmp++;
          n_bad++;
          $display("FAIL a_send_ready: got byte_ready_o=0 for %0d cycles, want 1", w);
          a_valid = 1'b0;
          return;
        end
      end
      tick();
    end
    a_valid = 1'b0;
  endtask

  task automatic a_wait_end(input int limit);
    int w = 0;
    while (!(a_done || a_err) && w < limit) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (!(a_done || a_err)) begin
      n_bad++;
      $display("FAIL a_wait_end: got no done/err within %0d cycles, want done or err", limit);
    end
  endtask

  task automatic a_check_words(input string name, input int nwords);
    n_cmp++;
    if (a_wr_q.size() != nwords) begin
      n_bad++;
      $display("FAIL %s_we_count: got %0d, want %0d", name, a_wr_q.size(), nwords);
    end
    for (int k = 0; k < nwords && k < a_wr_q.size(); k++) begin
      n_cmp++;
      if (a_wr_q[k] !== exp_word(k)) begin
        n_bad++;
        $display("FAIL %s_din[%0d]: got %h, want %h", name, k, a_wr_q[k], exp_word(k));
      end
    end
    n_cmp++;
    if (a_sum !== exp_sum(nwords)) begin
      n_bad++;
      $display("FAIL %s_checksum: got %h, want %h", name, a_sum, exp_sum(nwords));
    end
    n_cmp++;
    if (a_cnt !== 11'(nwords)) begin
      n_bad++;
      $display("FAIL %s_word_cnt: got %0d, want %0d", name, a_cnt, nwords);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({a_ready, a_ext, a_we, a_busy, a_done, a_err, a_din, a_cnt, a_sum} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: got rdy%b ext%b we%b busy%b done%b err%b din%h cnt%0d sum%h, want all 0",
               a_ready, a_ext, a_we, a_busy, a_done, a_err, a_din, a_cnt, a_sum);
    end
    n_cmp++;
    if ({b_ready, b_ext, b_we, b_busy, b_done, b_err, b_din, b_cnt, b_sum} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: got rdy%b ext%b we%b busy%b done%b err%b din%h cnt%0d sum%h, want all 0",
               b_ready, b_ext, b_we, b_busy, b_done, b_err, b_din, b_cnt, b_sum);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    tx_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    a_wr_q.delete();
    a_we_cyc.delete();
    a_early = 0;
    a_pulse_start();
    a_send(0, 8, 0);
    a_wait_end(40);
    a_check_words("basic", 2);
    n_cmp++;
    if (a_sum !== 32'hF0E2_1567) begin
      n_bad++;
      $display("FAIL basic_checksum_const: got %h, want f0e21567", a_sum);
    end
    n_cmp++;
    if ({a_done, a_err, a_ext, a_busy} !== 4'b1000) begin
      n_bad++;
      $display("FAIL basic_end_flags: got done%b err%b ext%b busy%b, want 1 0 0 0", a_done, a_err, a_ext, a_busy);
    end
    n_cmp++;
    if (a_early !== 0) begin
      n_bad++;
      $display("FAIL basic_arm_before_we: got %0d early writes, want 0", a_early);
    end
    if (a_we_cyc.size() == 2) begin
      n_cmp++;
      if (a_we_cyc[1] - a_we_cyc[0] !== 5) begin
        n_bad++;
        $display("FAIL basic_we_spacing: got %0d cycles, want 5", a_we_cyc[1] - a_we_cyc[0]);
      end
    end
  endtask

  task automatic test_toggle();
    a_wr_q.delete();
    a_pulse_start();
    a_send(0, 8, 1);
    a_wait_end(80);
    a_check_words("toggle", 2);
    n_cmp++;
    if (a_done !== 1'b1) begin
      n_bad++;
      $display("FAIL toggle_done: got %b, want 1", a_done);
    end
  endtask

  task automatic test_wrap_restart();
    tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    a_wr_q.delete();
    a_pulse_start();
    n_cmp++;
    if ({a_done, a_busy, a_ext, a_cnt, a_sum} !== {3'b011, 11'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL wrap_arm_clear: got done%b busy%b ext%b cnt%0d sum%h, want 0 1 1 0 0",
               a_done, a_busy, a_ext, a_cnt, a_sum);
    end
    a_send(0, 2, 0);
    a_pulse_start();
    n_cmp++;
    if (a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_start_ignored_ready: got %b, want 1", a_ready);
    end
    a_send(2, 8, 2);
    a_wait_end(80);
    a_check_words("wrap", 2);
    n_cmp++;
    if ({a_done, a_err} !== 2'b10 || a_sum !== 32'hFFFF_FFFE) begin
      n_bad++;
      $display("FAIL wrap_result: got done%b err%b sum%h, want 1 0 fffffffe", a_done, a_err, a_sum);
    end
  endtask

  task automatic test_start_rst();
    a_start = 1'b1;
    rst     = 1'b1;
    tick();
    a_start = 1'b0;
    rst     = 1'b0;
    n_cmp++;
    if ({a_ready, a_ext, a_we, a_busy, a_done, a_err, a_din, a_cnt, a_sum} !== '0) begin
      n_bad++;
      $display("FAIL start_rst: got rdy%b ext%b busy%b done%b cnt%0d sum%h, want all 0",
               a_ready, a_ext, a_busy, a_done, a_cnt, a_sum);
    end
    tick();
    n_cmp++;
    if (a_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL start_rst_idle: got busy %b, want 0", a_busy);
    end
  endtask

  task automatic test_timeout();
    tx_q.delete();
    for (int i = 0; i < 6; i++) tx_q.push_back(8'($urandom));
    a_wr_q.delete();
    a_pulse_start();
    a_send(0, 4, 0);
    a_send(4, 6, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) begin
        n_cmp++;
        if (a_err !== 1'b0) begin
          n_bad++;
          $display("FAIL timeout_early: got err %b after 7 idle cycles, want 0", a_err);
        end
      end
    end
    n_cmp++;
    if ({a_err, a_done, a_ext, a_busy} !== 4'b1000) begin
      n_bad++;
      $display("FAIL timeout_flags: got err%b done%b ext%b busy%b, want 1 0 0 0", a_err, a_done, a_ext, a_busy);
    end
    a_check_words("timeout", 1);
    repeat (5) tick();
    n_cmp++;
    if (a_err !== 1'b1 || a_wr_q.size() != 1) begin
      n_bad++;
      $display("FAIL timeout_sticky: got err %b writes %0d, want 1 1", a_err, a_wr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    tx_q.delete();
    for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom));
    a_pulse_start();
    a_send(0, 2, 0);
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({a_ready, a_ext, a_we, a_busy, a_done, a_err, a_din, a_cnt, a_sum} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got rdy%b ext%b we%b busy%b din%h cnt%0d sum%h, want all 0",
               a_ready, a_ext, a_we, a_busy, a_din, a_cnt, a_sum);
    end
    rst = 1'b0;
    tick();
    a_wr_q.delete();
    a_pulse_start();
    a_send(0, 8, 2);
    a_wait_end(80);
    a_check_words("reset_mid_reload", 2);
  endtask

  task automatic test_full_load();
    logic [31:0] s = 32'h0;
    logic [31:0] w;
    int wt;
    tx_b.delete();
    for (int i = 0; i < 768 * 4; i++) tx_b.push_back(8'($urandom));
    for (int i = 0; i < 1024; i++) b_mem[i] = 32'hx;
    b_writes = 0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < tx_b.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        b_valid = 1'b0;
        tick();
      end
      b_valid = 1'b1;
      b_byte  = tx_b[i];
      wt = 0;
      while (1) begin
        @(negedge clk);
        if (b_ready) break;
        wt++;
        if (wt > 40) break;
      end
      if (wt > 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL full_ready: got byte_ready_o=0 for %0d cycles at byte %0d, want 1", wt, i);
        b_valid = 1'b0;
        return;
      end
      tick();
    end
    b_valid = 1'b0;
    wt = 0;
    while (!b_done && wt < 20) begin
      tick();
      wt++;
    end
    n_cmp++;
    if ({b_done, b_err, b_ext} !== 3'b100 || b_cnt !== 11'd768) begin
      n_bad++;
      $display("FAIL full_end: got done%b err%b ext%b cnt%0d, want 1 0 0 768", b_done, b_err, b_ext, b_cnt);
    end
    n_cmp++;
    if (b_writes != 768) begin
      n_bad++;
      $display("FAIL full_writes: got %0d, want 768", b_writes);
    end
    for (int k = 0; k < 768; k++) begin
      w = {tx_b[4*k+3], tx_b[4*k+2], tx_b[4*k+1], tx_b[4*k]};
      s = s + w;
      n_cmp++;
      if (b_mem[k] !== w) begin
        n_bad++;
        $display("FAIL full_mem[%0d]: got %h, want %h", k, b_mem[k], w);
      end
    end
    n_cmp++;
    if (b_sum !== s) begin
      n_bad++;
      $display("FAIL full_checksum: got %h, want %h", b_sum, s);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_wrap_restart();
    test_start_rst();
    test_timeout();
    test_reset_mid();
    test_full_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
